// File: rtl/center_pkg.sv
// Shared types and constants for the centre filter and its per-axis EMA.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package center_pkg;

    localparam int X_DEFAULT = 360;
    localparam int Y_DEFAULT = 240;
    localparam int COORD_W   = 10;
    localparam int VEL_W     = 11;
    localparam int PIXCNT_W  = 20;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        UPDATE
    } state_t;

endpackage

// File: rtl/ema_axis.sv
// One axis of the target smoother: acquire, EMA step with clamp, optional deadband.
// Latency: smooth/vel register one cycle after enable.
// Backpressure: none; enable is a single-cycle strobe and is always accepted.
module ema_axis
    import center_pkg::*;
#(
    parameter int                 SHIFT     = 2,
    parameter int                 DEADBAND  = 2,
    parameter logic [COORD_W-1:0] RESET_VAL = COORD_W'(X_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COORD_W-1:0]        raw,
    input  logic                      load,
    input  logic                      step,
    input  logic                      enable,
    input  logic                      deadband,
    output logic [COORD_W-1:0]        smooth,
    output logic signed [VEL_W-1:0]   vel
);

    // Two guard bits keep the signed difference and the sum exact.
    localparam int DW = COORD_W + 2;

    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] stepVal;
    logic signed [DW-1:0] sum;
    logic        [DW-1:0] absDiff;
    logic        [COORD_W-1:0] smoothNext;
    logic                 inBand;

    // EMA candidate: arithmetic shift floors toward -inf, then clamp to the coordinate range
    always_comb begin
        diff    = $signed({2'b00, raw}) - $signed({2'b00, smooth});
        stepVal = diff >>> SHIFT;
        sum     = $signed({2'b00, smooth}) + stepVal;
        absDiff = diff[DW-1] ? DW'(-diff) : DW'(diff);
        inBand  = deadband && (absDiff <= DW'(DEADBAND));
        if (sum[DW-1]) begin
            smoothNext = '0;
        end else if (sum[DW-2:COORD_W] != '0) begin
            smoothNext = '1;
        end else begin
            smoothNext = sum[COORD_W-1:0];
        end
    end

    // Commit on the sample strobe: acquisition loads raw, tracking steps, a miss only zeroes velocity
    always_ff @(posedge clk) begin
        if (reset) begin
            smooth <= RESET_VAL;
            vel    <= '0;
        end else if (enable) begin
            if (load) begin
                smooth <= raw;
                vel    <= '0;
            end else if (step && !inBand) begin
                smooth <= smoothNext;
                vel    <= $signed({1'b0, smoothNext}) - $signed({1'b0, smooth});
            end else begin
                vel    <= '0;
            end
        end
    end

endmodule

// File: rtl/center_filter.sv
// Temporal filter on the colour centre-of-mass: EMA position, velocity, lost/valid tracking.
// Latency: frame start at T -> centre sampled at T+DIV_LATENCY+1, outputs and updated at T+DIV_LATENCY+2.
// Backpressure: none; streaming input, a new frame start during the divider wait drops the old frame.
// Optional deadband on small steps: define CENTER_FILTER_DEADBAND_EN.
module center_filter
    import center_pkg::*;
#(
    parameter int DIV_LATENCY = 40,
    parameter int SHIFT       = 2,
    parameter int MIN_PIXELS  = 64,
    parameter int LOST_FRAMES = 4,
    parameter int DEADBAND    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [10:0]              x,
    input  logic [9:0]               y,
    input  logic                     included,
    input  logic [COORD_W-1:0]       xCenter,
    input  logic [COORD_W-1:0]       yCenter,
    output logic [COORD_W-1:0]       xSmooth,
    output logic [COORD_W-1:0]       ySmooth,
    output logic signed [VEL_W-1:0]  xVel,
    output logic signed [VEL_W-1:0]  yVel,
    output logic                     valid,
    output logic                     lost,
    output logic                     updated
);

    localparam int WAIT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);

    state_t              state;
    state_t              nextState;
    logic                prevZero;
    logic                atOrigin;
    logic                frameStart;
    logic [PIXCNT_W-1:0] pixCnt;
    logic [PIXCNT_W-1:0] pixLatch;
    logic [WAIT_W-1:0]   waitCnt;
    logic [MISS_W-1:0]   missCnt;
    logic [MISS_W-1:0]   missNext;
    logic                sampleEn;
    logic                hit;
    logic                dbEn;

`ifdef CENTER_FILTER_DEADBAND_EN
    assign dbEn = 1'b1;
`else
    assign dbEn = 1'b0;
`endif

    assign atOrigin   = (x == '0) && (y == '0);
    assign frameStart = atOrigin && !prevZero;
    assign hit        = pixLatch >= PIXCNT_W'(MIN_PIXELS);
    assign missNext   = (missCnt == MISS_W'(LOST_FRAMES)) ? missCnt : missCnt + 1'b1;

    // Remember last cycle's origin so a held origin yields one frame start
    always_ff @(posedge clk) begin
        if (reset) prevZero <= 1'b0;
        else       prevZero <= atOrigin;
    end

    // Count qualifying pixels per frame; snapshot the finished frame's count at each frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            pixCnt   <= '0;
            pixLatch <= '0;
        end else if (frameStart) begin
            pixLatch <= pixCnt;
            pixCnt   <= {{(PIXCNT_W-1){1'b0}}, included};
        end else if (included && pixCnt != '1) begin
            pixCnt   <= pixCnt + 1'b1;
        end
    end

    // Divider settle timer: restarts on every frame start, counts down to zero and parks there
    always_ff @(posedge clk) begin
        if (reset)                 waitCnt <= '0;
        else if (frameStart)       waitCnt <= WAIT_W'(DIV_LATENCY - 1);
        else if (waitCnt != '0)    waitCnt <= waitCnt - 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next state; a nonzero timer in UPDATE means a frame start arrived during SAMPLE
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (frameStart) nextState = WAIT;
            WAIT:    if (!frameStart && waitCnt == '0) nextState = SAMPLE;
            SAMPLE:  nextState = UPDATE;
            UPDATE:  nextState = (frameStart || waitCnt != '0) ? WAIT : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode: results are committed in SAMPLE so they become visible with the UPDATE pulse
    always_comb begin
        sampleEn = (state == SAMPLE);
        updated  = (state == UPDATE);
    end

    // Hit/miss bookkeeping: a hit re-arms tracking, enough consecutive misses declare the target lost
    always_ff @(posedge clk) begin
        if (reset) begin
            missCnt <= '0;
            valid   <= 1'b0;
            lost    <= 1'b1;
        end else if (sampleEn) begin
            if (hit) begin
                missCnt <= '0;
                valid   <= 1'b1;
                lost    <= 1'b0;
            end else begin
                missCnt <= missNext;
                if (missNext == MISS_W'(LOST_FRAMES)) begin
                    valid <= 1'b0;
                    lost  <= 1'b1;
                end
            end
        end
    end

    ema_axis #(
        .SHIFT     (SHIFT),
        .DEADBAND  (DEADBAND),
        .RESET_VAL (COORD_W'(X_DEFAULT))
    ) u_xAxis (
        .clk      (clk),
        .reset    (reset),
        .raw      (xCenter),
        .load     (hit && !valid),
        .step     (hit && valid),
        .enable   (sampleEn),
        .deadband (dbEn),
        .smooth   (xSmooth),
        .vel      (xVel)
    );

    ema_axis #(
        .SHIFT     (SHIFT),
        .DEADBAND  (DEADBAND),
        .RESET_VAL (COORD_W'(Y_DEFAULT))
    ) u_yAxis (
        .clk      (clk),
        .reset    (reset),
        .raw      (yCenter),
        .load     (hit && !valid),
        .step     (hit && valid),
        .enable   (sampleEn),
        .deadband (dbEn),
        .smooth   (ySmooth),
        .vel      (yVel)
    );

endmodule

// File: tb/tb_center_filter.sv
// Self-checking bench for center_filter: frame-level reference model plus directed literal checks.
// Latency: model expects an update 42 cycles after an undisturbed frame start.
// Backpressure: n/a.
module tb_center_filter;

    localparam int LAT   = 40;
    localparam int MINP  = 64;
    localparam int LOSTN = 4;
    localparam int DB    = 2;
    localparam int NCYC  = 16384;
    localparam int CMAX  = (1 << 20) - 1;

    logic              clk;
    logic              reset;
    logic [10:0]       x;
    logic [9:0]        y;
    logic              included;
    logic [9:0]        xCenter;
    logic [9:0]        yCenter;
    logic [9:0]        xSmooth;
    logic [9:0]        ySmooth;
    logic signed [10:0] xVel;
    logic signed [10:0] yVel;
    logic              valid;
    logic              lost;
    logic              updated;

    int tests = 0;
    int fails = 0;

    center_filter #(
        .DIV_LATENCY (LAT),
        .SHIFT       (2),
        .MIN_PIXELS  (MINP),
        .LOST_FRAMES (LOSTN),
        .DEADBAND    (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .included (included),
        .xCenter  (xCenter),
        .yCenter  (yCenter),
        .xSmooth  (xSmooth),
        .ySmooth  (ySmooth),
        .xVel     (xVel),
        .yVel     (yVel),
        .valid    (valid),
        .lost     (lost),
        .updated  (updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model (frame level, per-cycle history) ----------------
    bit modelOn    = 0;
    bit modelReset = 0;
    bit startArr [NCYC];
    int latchArr [NCYC];
    int xcArr    [NCYC];
    int ycArr    [NCYC];
    int c;
    int mCnt, mx, my, mvx, mvy, mMiss;
    bit mValid, mLost, mPrevOrg;

    function automatic int floorDiv4(input int d);
        int q;
        q = d / 4;
        if (d < 0 && (d % 4) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int emaNext(input int s, input int r);
        int d, n;
        d = r - s;
`ifdef CENTER_FILTER_DEADBAND_EN
        if (d <= DB && d >= -DB) return s;
`endif
        n = s + floorDiv4(d);
        if (n < 0) n = 0;
        if (n > 1023) n = 1023;
        return n;
    endfunction

    task automatic applyFrame(input bit hit, input int rx, input int ry);
        int nx, ny;
        if (hit) begin
            if (!mValid) begin
                mx = rx; my = ry; mvx = 0; mvy = 0;
            end else begin
                nx = emaNext(mx, rx); ny = emaNext(my, ry);
                mvx = nx - mx; mvy = ny - my;
                mx = nx; my = ny;
            end
            mMiss = 0; mValid = 1; mLost = 0;
        end else begin
            mvx = 0; mvy = 0;
            if (mMiss < LOSTN) mMiss++;
            if (mMiss == LOSTN) begin mValid = 0; mLost = 1; end
        end
    endtask

    always @(negedge clk) begin
        bit org, fs, expUpd;
        if (modelOn) begin
            if (modelReset) begin
                c = 0; mCnt = 0; mx = 360; my = 240; mvx = 0; mvy = 0;
                mMiss = 0; mValid = 0; mLost = 1; mPrevOrg = 0;
                modelReset = 0;
            end
            if (c < NCYC) begin
                org = (x == 0) && (y == 0);
                fs  = org && !mPrevOrg;
                mPrevOrg = org;
                startArr[c] = fs;
                if (fs) begin
                    latchArr[c] = mCnt;
                    mCnt = included ? 1 : 0;
                end else if (included && mCnt < CMAX) begin
                    mCnt++;
                end
                xcArr[c] = int'(xCenter);
                ycArr[c] = int'(yCenter);
                expUpd = 0;
                if (c >= LAT + 2 && startArr[c-LAT-2]) begin
                    expUpd = 1;
                    for (int k = c - LAT - 1; k <= c - 2; k++) if (startArr[k]) expUpd = 0;
                end
                if (expUpd) applyFrame(latchArr[c-LAT-2] >= MINP, xcArr[c-1], ycArr[c-1]);
                tests++;
                if (updated !== expUpd || int'(xSmooth) != mx || int'(ySmooth) != my ||
                    int'(xVel) != mvx || int'(yVel) != mvy || valid !== mValid || lost !== mLost) begin
                    fails++;
                    $display("FAIL model cycle %0d: got upd=%0b xs=%0d ys=%0d xv=%0d yv=%0d v=%0b l=%0b, expected upd=%0b xs=%0d ys=%0d xv=%0d yv=%0d v=%0b l=%0b",
                             c, updated, xSmooth, ySmooth, xVel, yVel, valid, lost,
                             expUpd, mx, my, mvx, mvy, mValid, mLost);
                end
                c++;
            end else begin
                tests++; fails++;
                $display("FAIL model history: cycle %0d exceeds %0d", c, NCYC);
                modelOn = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit org, input bit inc, input int xc, input int yc);
        if (org) begin
            x = 11'd0; y = 10'd0;
        end else begin
            x = 11'($urandom_range(1, 1279));
            y = 10'($urandom_range(0, 719));
        end
        included = inc;
        xCenter  = 10'(xc);
        yCenter  = 10'(yc);
        @(posedge clk); #1;
    endtask

    task automatic frame(input int len, input int hold, input int nInc, input int xc, input int yc,
                         output int pulseAt, output int pulses);
        pulseAt = -1; pulses = 0;
        for (int i = 0; i < len; i++) begin
            if (updated) begin
                pulses++;
                if (pulseAt < 0) pulseAt = i;
            end
            drive(i < hold, i < nInc, xc, yc);
        end
    endtask

    task automatic doReset();
        modelOn = 0;
        reset = 1'b1; x = 11'd5; y = 10'd5; included = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst xSmooth", int'(xSmooth), 360);
        check("rst ySmooth", int'(ySmooth), 240);
        check("rst xVel", int'(xVel), 0);
        check("rst yVel", int'(yVel), 0);
        check("rst valid", int'(valid), 0);
        check("rst lost", int'(lost), 1);
        check("rst updated", int'(updated), 0);
        reset = 1'b0; modelReset = 1; modelOn = 1;
    endtask

    task automatic preRun(input int n);
        int p;
        p = 0;
        for (int i = 0; i < n; i++) begin
            if (updated) p++;
            drive(0, 1, 0, 0);
        end
        check("idle no pulse", p, 0);
    endtask

    initial begin
        int pa, pc, len, hold, ninc, xc, yc;
        reset = 1'b1; x = 11'd5; y = 10'd5; included = 1'b0; xCenter = '0; yCenter = '0;

        doReset();
        preRun(100);
        check("idle xSmooth", int'(xSmooth), 360);

        // acquisition
        frame(120, 1, 100, 500, 100, pa, pc);
        check("acq pulse cycle", pa, 42);
        check("acq pulse count", pc, 1);
        check("acq xSmooth", int'(xSmooth), 500);
        check("acq ySmooth", int'(ySmooth), 100);
        check("acq valid", int'(valid), 1);
        check("acq lost", int'(lost), 0);
        check("acq xVel", int'(xVel), 0);
        // EMA steps
        frame(120, 1, 100, 600, 100, pa, pc);
        check("ema up xSmooth", int'(xSmooth), 525);
        check("ema up xVel", int'(xVel), 25);
        frame(120, 1, 10, 400, 100, pa, pc);
        check("ema down xSmooth", int'(xSmooth), 493);
        check("ema down xVel", int'(xVel), -32);
        // four misses
        frame(120, 1, 10, 800, 800, pa, pc);
        frame(120, 1, 10, 800, 800, pa, pc);
        frame(120, 1, 10, 800, 800, pa, pc);
        check("miss3 valid", int'(valid), 1);
        check("miss3 xSmooth", int'(xSmooth), 493);
        check("miss3 pulse count", pc, 1);
        frame(120, 1, 100, 800, 800, pa, pc);
        check("miss4 valid", int'(valid), 0);
        check("miss4 lost", int'(lost), 1);
        check("miss4 xVel", int'(xVel), 0);
        check("miss4 xSmooth", int'(xSmooth), 493);
        // reacquire
        frame(120, 1, 100, 50, 60, pa, pc);
        check("reacq xSmooth", int'(xSmooth), 50);
        check("reacq valid", int'(valid), 1);
        // short frame dropped, held origin gives one start
        frame(20, 1, 20, 700, 700, pa, pc);
        check("short no pulse", pc, 0);
        frame(120, 1, 100, 70, 70, pa, pc);
        check("after short pulse cycle", pa, 42);
        check("after short pulse count", pc, 1);
        frame(120, 5, 100, 90, 90, pa, pc);
        check("held origin pulse cycle", pa, 42);
        check("held origin pulse count", pc, 1);

`ifdef CENTER_FILTER_DEADBAND_EN
        doReset();
        preRun(100);
        frame(120, 1, 100, 300, 300, pa, pc);
        check("db acq xSmooth", int'(xSmooth), 300);
        frame(120, 1, 100, 302, 300, pa, pc);
        check("db hold xSmooth", int'(xSmooth), 300);
        check("db hold xVel", int'(xVel), 0);
        frame(120, 1, 100, 310, 300, pa, pc);
        check("db step xSmooth", int'(xSmooth), 302);
        check("db step xVel", int'(xVel), 2);
`endif

        // randomized frames
        xc = 512; yc = 300;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) < 7) len = $urandom_range(60, 130);
            else                          len = $urandom_range(20, 45);
            hold = $urandom_range(1, 3);
            ninc = $urandom_range(0, len);
            if ($urandom_range(0, 1) == 1) begin
                xc = $urandom_range(0, 1023); yc = $urandom_range(0, 1023);
            end else begin
                xc = (xc + $urandom_range(0, 12) + 1018) % 1024;
                yc = (yc + $urandom_range(0, 12) + 1018) % 1024;
            end
            frame(len, hold, ninc, xc, yc, pa, pc);
        end

        // reset in the middle of a frame's divider wait
        frame(30, 1, 30, 123, 456, pa, pc);
        doReset();
        for (int f = 0; f < 20; f++) begin
            len  = $urandom_range(30, 130);
            ninc = $urandom_range(len / 2, len);
            frame(len, $urandom_range(1, 2), ninc, $urandom_range(0, 1023), $urandom_range(0, 1023), pa, pc);
        end
        frame(60, 0, 0, 0, 0, pa, pc);

        modelOn = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
